// File: rtl/cap_check_pkg.sv
// cap_check_pkg: cause codes, request/response types and access size helper for the capability checker
package cap_check_pkg;
    localparam logic [2:0] NONE   = 3'd0;
    localparam logic [2:0] TAG    = 3'd1;
    localparam logic [2:0] BOUNDS = 3'd2;
    localparam logic [2:0] PERM   = 3'd3;
    typedef struct packed {
        logic tag;
        logic need_load;
        logic need_store;
        logic need_exec;
        logic perm_load;
        logic perm_store;
        logic perm_exec;
    } cap_req;
    typedef struct packed {
        logic       ok;
        logic [2:0] cause;
    } cap_rsp;
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        return (4'd1 << size) - 4'd1;
    endfunction
endpackage

// File: rtl/cap_check_core.sv
// cap_check_core: combinational priority checker producing the tag/bounds/permission verdict
module cap_check_core
    import cap_check_pkg::*;
#(
    parameter int AW = 64
) (
    input  logic [AW:0] top,
    input  logic [AW:0] last,
    input  logic        below,
    input  cap_req      req,
    output cap_rsp      rsp
);
    logic       need;
    logic       lack;
    logic [2:0] cause;
    always_comb begin
        need = req.need_load | req.need_store | req.need_exec;
        lack = (req.need_load & ~req.perm_load) | (req.need_store & ~req.perm_store) |
               (req.need_exec & ~req.perm_exec);
        cause = !need ? NONE : !req.tag ? TAG : (below || last >= top) ? BOUNDS : lack ? PERM : NONE;
        rsp.ok = cause == NONE;
        rsp.cause = cause;
    end
endmodule

// File: rtl/cap_check_pipe.sv
// cap_check_pipe: 2-stage capability access checker; fault record built only with CAP_CHECK_FAULT_LOG_EN
module cap_check_pipe
    import cap_check_pkg::*;
#(
    parameter int AW   = 64,
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_id,
    input  logic            cap_tag,
    input  logic [AW-1:0]   cap_base,
    input  logic [AW-1:0]   cap_length,
    input  logic [AW-1:0]   acc_addr,
    input  logic [1:0]      acc_size,
    input  logic            need_load,
    input  logic            need_store,
    input  logic            need_exec,
    input  logic            perm_load,
    input  logic            perm_store,
    input  logic            perm_exec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_id,
    output logic            out_ok,
    output logic [2:0]      out_cause,
    output logic            fault_valid,
    output logic [2:0]      fault_cause,
    output logic [AW-1:0]   fault_addr,
    output logic [15:0]     fault_count,
    input  logic            fault_clear
);
    logic            adv;
    logic            s1_valid;
    logic            s1_below;
    logic [AW:0]     s1_top;
    logic [AW:0]     s1_last;
    logic [AW-1:0]   s1_addr;
    logic [AW-1:0]   out_addr;
    logic [ID_W-1:0] s1_id;
    cap_req          s1_req;
    cap_rsp          rsp;
    assign adv = !out_valid || out_ready;
    assign in_ready = adv;
    cap_check_core #(.AW(AW)) u_core (
        .top   (s1_top),
        .last  (s1_last),
        .below (s1_below),
        .req   (s1_req),
        .rsp   (rsp)
    );
    // Carry bit kept so a last byte past 2^AW compares above any top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_below <= 1'b0;
            s1_top <= '0;
            s1_last <= '0;
            s1_addr <= '0;
            s1_id <= '0;
            s1_req <= '0;
            out_valid <= 1'b0;
            out_id <= '0;
            out_ok <= 1'b0;
            out_cause <= NONE;
            out_addr <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_below <= acc_addr < cap_base;
            s1_top <= {1'b0, cap_base} + {1'b0, cap_length};
            s1_last <= {1'b0, acc_addr} + (AW+1)'(size_mask(acc_size));
            s1_addr <= acc_addr;
            s1_id <= in_id;
            s1_req <= '{tag: cap_tag, need_load: need_load, need_store: need_store,
                        need_exec: need_exec, perm_load: perm_load, perm_store: perm_store,
                        perm_exec: perm_exec};
            out_valid <= s1_valid;
            out_id <= s1_id;
            out_ok <= rsp.ok;
            out_cause <= rsp.cause;
            out_addr <= s1_addr;
        end
    end
`ifdef CAP_CHECK_FAULT_LOG_EN
    logic fire;
    assign fire = out_valid && out_ready && !out_ok;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || fault_clear) begin
            fault_valid <= 1'b0;
            fault_cause <= NONE;
            fault_addr <= '0;
            fault_count <= '0;
        end else if (fire) begin
            if (!fault_valid) begin
                fault_valid <= 1'b1;
                fault_cause <= out_cause;
                fault_addr <= out_addr;
            end
            if (fault_count != 16'hFFFF) fault_count <= fault_count + 16'd1;
        end
    end
`else
    logic unused_log;
    assign unused_log = ^{fault_clear, out_addr};
    assign fault_valid = 1'b0;
    assign fault_cause = NONE;
    assign fault_addr = '0;
    assign fault_count = '0;
`endif
endmodule

// File: tb/tb_cap_check_pipe.sv
// tb_cap_check_pipe: directed and randomized checks of cap_check_pipe against an arithmetic reference model
module tb_cap_check_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_id = '0;
    logic        cap_tag = 1'b0;
    logic [63:0] cap_base = '0;
    logic [63:0] cap_length = '0;
    logic [63:0] acc_addr = '0;
    logic [1:0]  acc_size = '0;
    logic [2:0]  r_need = '0;
    logic [2:0]  r_perm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_id;
    logic        out_ok;
    logic [2:0]  out_cause;
    logic        fault_valid;
    logic [2:0]  fault_cause;
    logic [63:0] fault_addr;
    logic [15:0] fault_count;
    logic        fault_clear = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic        o_rdy, o_v0, o_v1, o_ok;
    logic [3:0]  o_id;
    logic [2:0]  o_c;

    always #5 clk = ~clk;

    cap_check_pipe #(.AW(64), .ID_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .cap_tag(cap_tag), .cap_base(cap_base), .cap_length(cap_length), .acc_addr(acc_addr),
        .acc_size(acc_size), .need_load(r_need[0]), .need_store(r_need[1]), .need_exec(r_need[2]),
        .perm_load(r_perm[0]), .perm_store(r_perm[1]), .perm_exec(r_perm[2]),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_ok(out_ok),
        .out_cause(out_cause), .fault_valid(fault_valid), .fault_cause(fault_cause),
        .fault_addr(fault_addr), .fault_count(fault_count), .fault_clear(fault_clear)
    );

    // Access is legal when [addr, addr+n) lies inside [base, base+len), computed without overflow
    function automatic logic [2:0] ref_cause(logic tag, logic [63:0] base, logic [63:0] len,
                                             logic [63:0] addr, logic [1:0] size,
                                             logic [2:0] need, logic [2:0] perm);
        logic [65:0] end_excl, limit;
        end_excl = {2'b0, addr} + (66'd1 << size);
        limit = {2'b0, base} + {2'b0, len};
        if (need == 3'b000) return 3'd0;
        if (!tag) return 3'd1;
        if (addr < base || end_excl > limit) return 3'd2;
        if ((need & ~perm) != 3'b000) return 3'd3;
        return 3'd0;
    endfunction

    task automatic set_req(input logic tag, input logic [63:0] base, input logic [63:0] len,
                           input logic [63:0] addr, input logic [1:0] size,
                           input logic [2:0] need, input logic [2:0] perm);
        cap_tag = tag; cap_base = base; cap_length = len; acc_addr = addr;
        acc_size = size; r_need = need; r_perm = perm;
    endtask

    task automatic rand_req();
        cap_tag = $urandom_range(0, 7) != 0;
        cap_base = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 64))
                                               : {$urandom, $urandom};
        cap_length = 64'($urandom_range(0, 72));
        acc_addr = cap_base + 64'($urandom_range(0, 80)) - 64'd8;
        acc_size = 2'($urandom_range(0, 3));
        r_need = 3'($urandom_range(0, 7));
        r_perm = $urandom_range(0, 1) ? 3'b111 : 3'($urandom_range(0, 7));
    endtask

    task automatic issue(input logic clr);
        @(posedge clk) #1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk) o_rdy = in_ready;
        @(posedge clk) #1 in_valid = 1'b0;
        @(negedge clk) o_v0 = out_valid;
        @(posedge clk) #1 fault_clear = clr;
        @(negedge clk) begin o_v1 = out_valid; o_id = out_id; o_ok = out_ok; o_c = out_cause; end
        @(posedge clk) #1 fault_clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_ok, out_cause, out_id, fault_valid, fault_cause, fault_addr, fault_count} !== '0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b ok=%b cause=%0d id=%0d fv=%b fc=%0d fa=%h cnt=%0d, required all 0",
                     out_valid, out_ok, out_cause, out_id, fault_valid, fault_cause, fault_addr, fault_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_bounds();
        logic [63:0] t_base [7] = '{64'h1000, 64'h1000, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF0,
                                    64'h1000, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF0};
        logic [63:0] t_len  [7] = '{64'h100, 64'h100, 64'h100, 64'h10, 64'h0, 64'h100, 64'h10};
        logic [63:0] t_addr [7] = '{64'h10FC, 64'h10FD, 64'h0FFF, 64'hFFFF_FFFF_FFFF_FFFC,
                                    64'h1000, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8};
        logic [1:0]  t_size [7] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd3};
        logic [2:0]  t_exp  [7] = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0};
        for (int i = 0; i < 7; i++) begin
            set_req(1'b1, t_base[i], t_len[i], t_addr[i], t_size[i], 3'b001, 3'b001);
            in_id = 4'(i + 3);
            issue(1'b0);
            checks++;
            if (o_rdy !== 1'b1 || o_v0 !== 1'b0 || o_v1 !== 1'b1) begin
                errors++;
                $display("FAIL bounds_latency[%0d]: ready=%b valid@1=%b valid@2=%b, required 1 0 1", i, o_rdy, o_v0, o_v1);
            end
            checks++;
            if (o_id !== 4'(i + 3) || o_ok !== (t_exp[i] == 3'd0) || o_c !== t_exp[i]) begin
                errors++;
                $display("FAIL bounds_result[%0d]: id=%0d ok=%b cause=%0d, required id=%0d ok=%b cause=%0d",
                         i, o_id, o_ok, o_c, i + 3, t_exp[i] == 3'd0, t_exp[i]);
            end
        end
    endtask

    task automatic test_priority();
        logic       t_tag  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [63:0] t_addr [4] = '{64'h3000, 64'h1010, 64'h9000, 64'h3000};
        logic [2:0] t_need [4] = '{3'b001, 3'b010, 3'b000, 3'b010};
        logic [2:0] t_perm [4] = '{3'b000, 3'b101, 3'b000, 3'b000};
        logic [2:0] t_exp  [4] = '{3'd1, 3'd3, 3'd0, 3'd2};
        for (int i = 0; i < 4; i++) begin
            set_req(t_tag[i], 64'h1000, 64'h100, t_addr[i], 2'd0, t_need[i], t_perm[i]);
            in_id = 4'(i);
            issue(1'b0);
            checks++;
            if (o_v1 !== 1'b1 || o_ok !== (t_exp[i] == 3'd0) || o_c !== t_exp[i]) begin
                errors++;
                $display("FAIL priority[%0d]: valid=%b ok=%b cause=%0d, required valid=1 ok=%b cause=%0d",
                         i, o_v1, o_ok, o_c, t_exp[i] == 3'd0, t_exp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] exp;
        for (int i = 0; i < 40; i++) begin
            rand_req();
            in_id = 4'($urandom_range(0, 15));
            exp = ref_cause(cap_tag, cap_base, cap_length, acc_addr, acc_size, r_need, r_perm);
            issue(1'b0);
            checks++;
            if (o_v1 !== 1'b1 || o_id !== in_id || o_ok !== (exp == 3'd0) || o_c !== exp) begin
                errors++;
                $display("FAIL random[%0d]: valid=%b id=%0d ok=%b cause=%0d, required valid=1 id=%0d ok=%b cause=%0d",
                         i, o_v1, o_id, o_ok, o_c, in_id, exp == 3'd0, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] q_id [$];
        logic [2:0] q_c [$];
        int         sent = 0;
        int         got = 0;
        logic       held = 1'b0;
        logic       took = 1'b0;
        logic [3:0] h_id;
        logic       h_ok;
        logic [2:0] h_c;
        rand_req();
        in_id = 4'd0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            @(posedge clk) #1;
            if (took) begin rand_req(); in_id = 4'(sent); end
            in_valid = sent < 8;
            out_ready = cyc[0];
            @(negedge clk);
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_id !== h_id || out_ok !== h_ok || out_cause !== h_c) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b id=%0d ok=%b cause=%0d, required 1 %0d %b %0d",
                             out_valid, out_id, out_ok, out_cause, h_id, h_ok, h_c);
                end
            end
            held = out_valid && !out_ready;
            h_id = out_id; h_ok = out_ok; h_c = out_cause;
            if (out_valid && out_ready) begin
                checks++;
                if (q_id.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_order: unexpected result id=%0d, required none", out_id);
                end else begin
                    if (out_id !== q_id[0] || out_ok !== (q_c[0] == 3'd0) || out_cause !== q_c[0]) begin
                        errors++;
                        $display("FAIL b2b_result: id=%0d ok=%b cause=%0d, required id=%0d ok=%b cause=%0d",
                                 out_id, out_ok, out_cause, q_id[0], q_c[0] == 3'd0, q_c[0]);
                    end
                    void'(q_id.pop_front());
                    void'(q_c.pop_front());
                end
                got++;
            end
            took = in_valid && in_ready;
            if (took) begin
                q_id.push_back(in_id);
                q_c.push_back(ref_cause(cap_tag, cap_base, cap_length, acc_addr, acc_size, r_need, r_perm));
                sent++;
            end
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (sent != 8 || got != 8) begin
            errors++;
            $display("FAIL b2b_count: sent=%0d returned=%0d, required 8 8", sent, got);
        end
    endtask

`ifdef CAP_CHECK_FAULT_LOG_EN
    task automatic test_fault_log();
        @(posedge clk) #1 fault_clear = 1'b1;
        @(posedge clk) #1 fault_clear = 1'b0;
        set_req(1'b1, 64'h1000, 64'h100, 64'h2000, 2'd0, 3'b001, 3'b001);
        issue(1'b0);
        set_req(1'b0, 64'h1000, 64'h100, 64'h1010, 2'd0, 3'b001, 3'b001);
        issue(1'b0);
        set_req(1'b1, 64'h1000, 64'h100, 64'h1010, 2'd0, 3'b100, 3'b011);
        issue(1'b0);
        @(negedge clk);
        checks++;
        if (fault_valid !== 1'b1 || fault_cause !== 3'd2 || fault_addr !== 64'h2000 || fault_count !== 16'd3) begin
            errors++;
            $display("FAIL fault_record: valid=%b cause=%0d addr=%h count=%0d, required 1 2 2000 3",
                     fault_valid, fault_cause, fault_addr, fault_count);
        end
        set_req(1'b0, 64'h1000, 64'h100, 64'h1010, 2'd0, 3'b001, 3'b001);
        issue(1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (fault_valid !== 1'b0 || fault_cause !== 3'd0 || fault_addr !== 64'h0 || fault_count !== 16'd0) begin
            errors++;
            $display("FAIL fault_clear: valid=%b cause=%0d addr=%h count=%0d, required all 0",
                     fault_valid, fault_cause, fault_addr, fault_count);
        end
    endtask
`else
    task automatic test_fault_log();
        set_req(1'b0, 64'h1000, 64'h100, 64'h2000, 2'd0, 3'b001, 3'b001);
        issue(1'b0);
        @(negedge clk);
        checks++;
        if (fault_valid !== 1'b0 || fault_cause !== 3'd0 || fault_addr !== 64'h0 || fault_count !== 16'd0) begin
            errors++;
            $display("FAIL fault_tied: valid=%b cause=%0d addr=%h count=%0d, required all 0",
                     fault_valid, fault_cause, fault_addr, fault_count);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int seen = 0;
        set_req(1'b1, 64'h1000, 64'h100, 64'h1010, 2'd0, 3'b001, 3'b001);
        @(posedge clk) #1 in_valid = 1'b1;
        @(posedge clk) #2 rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: results=%0d in_ready=%b, required 0 1", seen, in_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bounds();
        test_priority();
        test_random();
        test_back_to_back();
        test_fault_log();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
